serial_writer: RTL and testbench
================================

SERIAL_WRITER -- requirements
Module: serial_writer

Interface
REQ-001 Parameter DATA_W, default 12, width of signed out_data; SHALL be >= 10.
REQ-002 clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 go  input  1  start request; sampled only in IDLE.
REQ-005 mode  input  2  0: int8, 1: int6, 2: fp4, 3: reserved; sampled with go.
REQ-006 in_valid  input  1  term inputs valid this cycle.
REQ-007 sign  input  1  term sign, 1 = negative.
REQ-008 exp  input  2  term exponent field.
REQ-009 mantissa  input  1  term mantissa bit.
REQ-010 bsig  input  3  term bit-significance (left shift).
REQ-011 out_ready  input  1  consumer accepts out_data.
REQ-012 busy  output  1  high in COLLECT and DONE.
REQ-013 out_valid  output  1  reassembled value available.
REQ-014 out_data  output  DATA_W  signed two's-complement reassembled value.
REQ-015 bsig_err  output  1  sticky: a term arrived with unexpected bsig.

Function
REQ-016 States SHALL be IDLE, COLLECT, DONE.
REQ-017 IDLE: go=1 with mode 0/1/2 -> latch mode, clear acc, count, and bsig_err; next state COLLECT.
REQ-018 IDLE: go=1 with mode=3 SHALL be ignored; state stays IDLE.
REQ-019 go SHALL be ignored in COLLECT and DONE.
REQ-020 Terms per transaction: int8 = 4, int6 = 3, fp4 = 2.
REQ-021 COLLECT: a term is accepted on each cycle with in_valid=1; cycles with in_valid=0 SHALL leave acc and count unchanged.
REQ-022 Int-mode term magnitude SHALL be (exp[0] ? 2 : mantissa); exp[1] is ignored.
REQ-023 Fp4-mode term magnitude SHALL be mantissa << exp.
REQ-024 Term value SHALL be (sign ? -mag : +mag) << bsig, sign-extended to DATA_W; acc <= acc + term, with wrap-around modulo 2^DATA_W and no saturation.
REQ-025 Expected bsig: 2*count in int modes, count in fp4.
REQ-026 On mismatch, bsig_err SHALL set and the term SHALL still be accumulated using the received bsig.
REQ-027 On acceptance of the last term -> DONE in the next cycle; out_data = acc including that term.
REQ-028 DONE: out_valid=1, out_data held stable until out_ready=1; on out_valid & out_ready -> IDLE in the next cycle, out_valid drops.
REQ-029 out_ready while not in DONE SHALL have no effect.
REQ-030 in_valid in IDLE or DONE SHALL be ignored; no term accepted.
REQ-031 Latency: the last term is accepted at edge N; out_valid is high after edge N (registered, no combinational in->out path).
REQ-032 out_data SHALL keep its last value in IDLE and COLLECT; it updates only on entry to DONE.
REQ-033 bsig_err SHALL hold until the next accepted go.
REQ-034 Back-to-back: go may be accepted in the first IDLE cycle after the handshake.

Reset
REQ-035 Asserting reset at any time, including mid-COLLECT or in DONE, SHALL immediately force state IDLE, acc=0, count=0, out_valid=0, busy=0, out_data=0, bsig_err=0.
REQ-036 After deassertion, the block SHALL accept go on the first rising edge.

Verification
REQ-037 Int8 -128: go, mode=0; terms (s,e,m,b) = (0,0,0,0), (0,0,0,2), (0,0,0,4), (1,1,1,6) -> out_data=-128, bsig_err=0, out_valid the cycle after the 4th term.
REQ-038 Int8 +127 with bubbles: terms (1,0,1,0), (0,0,0,2), (0,0,0,4), (0,1,1,6), in_valid=0 between each term -> out_data=127, same value as with no bubbles.
REQ-039 Fp4: mode=2; terms (1,2,1,0), (1,1,1,1) -> out_data=-8; out_valid held 3 cycles with out_ready=0, then released with out_ready=1 -> IDLE.
REQ-040 Bsig error: int6; terms with bsig 0, 3, 4 (all +1) -> out_data=25, bsig_err=1; bsig_err clears on the next go.
REQ-041 Reset in COLLECT after 2 int8 terms -> all outputs 0; a following full int8 transaction returns the correct value unaffected.
REQ-042 Ignored inputs: mode=3 go -> stays IDLE; go asserted in COLLECT -> no restart; in_valid in DONE -> out_data unchanged.

Source files
------------

// File: rtl/serial_writer.sv
// serial_writer: reassembles a signed value from serially arriving sign/exp/mantissa/bsig terms
module serial_writer #(
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic [1:0]               mode,
  input  logic                     in_valid,
  input  logic                     sign,
  input  logic [1:0]               exp,
  input  logic                     mantissa,
  input  logic [2:0]               bsig,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     bsig_err
);
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  state_t              state;
  logic [1:0]          mode_r;
  logic [1:0]          count;
  logic [DATA_W-1:0]   acc;
  logic [3:0]          mag;
  logic [DATA_W-1:0]   mag_x;
  logic [DATA_W-1:0]   term;
  logic [DATA_W-1:0]   acc_next;
  logic [2:0]          exp_b;
  logic                last;
  // term decode: magnitude, signed shifted value, expected bsig and last-term flag
  always_comb begin
    mag      = (mode_r == 2'd2) ? ({3'd0, mantissa} << exp) : (exp[0] ? 4'd2 : {3'd0, mantissa});
    mag_x    = {{(DATA_W-4){1'b0}}, mag};
    term     = (sign ? (~mag_x + 1'b1) : mag_x) << bsig;
    acc_next = acc + term;
    exp_b    = (mode_r == 2'd2) ? {1'b0, count} : {count, 1'b0};
    last     = count == ((mode_r == 2'd0) ? 2'd3 : (mode_r == 2'd1) ? 2'd2 : 2'd1);
  end
  // control FSM with registered outputs; async active-low reset clears everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mode_r    <= 2'd0;
      acc       <= '0;
      count     <= 2'd0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      bsig_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (go && mode != 2'd3) begin
          mode_r   <= mode;
          acc      <= '0;
          count    <= 2'd0;
          bsig_err <= 1'b0;
          busy     <= 1'b1;
          state    <= COLLECT;
        end
        COLLECT: if (in_valid) begin
          acc   <= acc_next;
          count <= count + 2'd1;
          if (bsig != exp_b) bsig_err <= 1'b1;
          if (last) begin
            out_data  <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_writer.sv
// tb_serial_writer: directed table-driven bench for serial_writer
module tb_serial_writer;
  logic clk = 0, reset = 0, go = 0, in_valid = 0, sign = 0, mantissa = 0, out_ready = 0;
  logic [1:0] mode = 0, exp = 0;
  logic [2:0] bsig = 0;
  logic busy, out_valid, bsig_err;
  logic signed [11:0] out_data;
  int checks = 0, errors = 0;

  serial_writer #(.DATA_W(12)) dut (
    .clk(clk), .reset(reset), .go(go), .mode(mode), .in_valid(in_valid), .sign(sign),
    .exp(exp), .mantissa(mantissa), .bsig(bsig), .out_ready(out_ready), .busy(busy),
    .out_valid(out_valid), .out_data(out_data), .bsig_err(bsig_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       md;
    int               n;
    logic [3:0][6:0]  t;
    logic signed [11:0] d;
    logic             err;
  } vec_t;
  vec_t vecs[7];

  function automatic logic [6:0] mk(input logic s, input logic [1:0] e, input logic m, input logic [2:0] b);
    return {s, e, m, b};
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] md);
    go = 1; mode = md;
    tick();
    go = 0; mode = 0;
  endtask

  task automatic term(input logic [6:0] t);
    {sign, exp, mantissa, bsig} = t;
    in_valid = 1;
    tick();
    in_valid = 0; {sign, exp, mantissa, bsig} = '0;
  endtask

  task automatic finish_txn(input string name, input int d, input int err);
    chk({name, " out_valid"}, int'(out_valid), 1);
    chk({name, " out_data"}, int'(out_data), d);
    chk({name, " bsig_err"}, int'(bsig_err), err);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk({name, " out_valid drop"}, int'(out_valid), 0);
    chk({name, " busy drop"}, int'(busy), 0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    start(v.md);
    chk({name, " busy"}, int'(busy), 1);
    chk({name, " err cleared"}, int'(bsig_err), 0);
    for (int k = 0; k < v.n; k++) begin
      chk({name, " no early valid"}, int'(out_valid), 0);
      term(v.t[k]);
    end
    finish_txn(name, int'(v.d), int'(v.err));
  endtask

  initial begin
    vecs[0] = '{2'd0, 4, {mk(1,1,1,6), mk(0,0,0,4), mk(0,0,0,2), mk(0,0,0,0)}, -12'sd128, 1'b0};
    vecs[1] = '{2'd1, 3, {7'd0, mk(0,0,1,4), mk(0,0,1,3), mk(0,0,1,0)}, 12'sd25, 1'b1};
    vecs[2] = '{2'd2, 2, {14'd0, mk(1,1,1,1), mk(1,2,1,0)}, -12'sd8, 1'b0};
    vecs[3] = '{2'd0, 4, {mk(0,0,1,6), mk(1,2,1,4), mk(0,3,0,2), mk(0,2,1,0)}, 12'sd57, 1'b0};
    vecs[4] = '{2'd2, 2, {14'd0, mk(0,3,1,7), mk(0,3,1,7)}, -12'sd2048, 1'b1};
    vecs[5] = '{2'd1, 3, {7'd0, mk(0,1,1,4), mk(1,0,1,2), mk(1,1,0,0)}, 12'sd26, 1'b0};
    vecs[6] = '{2'd2, 2, {14'd0, mk(1,0,1,1), mk(0,3,0,0)}, -12'sd2, 1'b0};

    tick(); tick();
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset out_data", int'(out_data), 0);
    chk("reset bsig_err", int'(bsig_err), 0);
    reset = 1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // bubbles between int8 terms
    start(2'd0);
    term(mk(1,0,1,0)); tick();
    term(mk(0,0,0,2)); tick();
    term(mk(0,0,0,4)); tick();
    chk("bubble no valid", int'(out_valid), 0);
    term(mk(0,1,1,6));
    finish_txn("bubble", 127, 0);

    // fp4 held in DONE, in_valid ignored there
    start(2'd2);
    term(mk(1,2,1,0));
    term(mk(1,1,1,1));
    for (int c = 0; c < 3; c++) begin
      in_valid = 1; sign = 0; exp = 2'd3; mantissa = 1; bsig = 3'd7;
      tick();
      in_valid = 0;
      chk("hold out_valid", int'(out_valid), 1);
      chk("hold out_data", int'(out_data), -8);
      chk("hold busy", int'(busy), 1);
    end
    finish_txn("hold", -8, 0);

    // async reset in COLLECT after two terms
    start(2'd0);
    term(mk(1,1,1,6));
    term(mk(0,1,1,2));
    #2 reset = 0;
    #1;
    chk("mid reset out_data", int'(out_data), 0);
    chk("mid reset busy", int'(busy), 0);
    chk("mid reset out_valid", int'(out_valid), 0);
    tick();
    reset = 1;
    run_vec(vecs[0], "post reset");

    // reset in DONE
    start(2'd2);
    term(mk(0,1,1,0));
    term(mk(0,1,1,1));
    chk("pre done reset valid", int'(out_valid), 1);
    reset = 0; #1;
    chk("done reset out_valid", int'(out_valid), 0);
    chk("done reset out_data", int'(out_data), 0);
    tick(); reset = 1;

    // ignored inputs: mode 3, in_valid/out_ready in IDLE, go in COLLECT
    start(2'd3);
    chk("mode3 busy", int'(busy), 0);
    term(mk(0,1,1,0));
    out_ready = 1; tick(); out_ready = 0;
    chk("idle term busy", int'(busy), 0);
    start(2'd0);
    term(mk(0,0,1,0));
    go = 1; mode = 2'd2; out_ready = 1;
    term(mk(0,1,1,2));
    go = 0; mode = 0; out_ready = 0;
    chk("go in collect busy", int'(busy), 1);
    chk("go in collect valid", int'(out_valid), 0);
    term(mk(0,0,0,4));
    term(mk(1,0,1,6));
    finish_txn("no restart", 1 + 8 - 64, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
